// File: rtl/enc_round_sched.sv
// enc_round_sched: iterative 12-bit SPN encryption round scheduler.
// A single round datapath (state + key registers) is reused for ROUNDS
// cycles per block. Plaintext/key enter via valid/ready and the ciphertext
// leaves via valid/ready. ROUNDS must lie in 1..15 (4-bit round counter).
module enc_round_sched #(
    parameter int ROUNDS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] din,
    input  logic [11:0] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] dout,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST = 4'(ROUNDS);

    state_t      state;
    logic [11:0] st;
    logic [11:0] kr;
    logic [3:0]  cnt;
    logic [11:0] st_next;

    // 3-bit substitution box, result packed as {sbo2, sbo1, sbo0}
    function automatic logic [2:0] sbox(input logic [2:0] sbi);
        return {~sbi[1] ^ sbi[0] ^ sbi[2], ~sbi[1], sbi[0]};
    endfunction

    // Four S-boxes; each group lands two bits higher, group 3 wraps around
    function automatic logic [11:0] spn(input logic [11:0] si);
        logic [2:0] g0, g1, g2, g3;
        g0 = sbox(si[2:0]);
        g1 = sbox(si[5:3]);
        g2 = sbox(si[8:6]);
        g3 = sbox(si[11:9]);
        return {g3[0], g2, g1, g0, g3[2:1]};
    endfunction

    // Key schedule step: key XOR inverted left-rotate-by-one of itself
    function automatic logic [11:0] ka(input logic [11:0] k);
        return k ^ ~{k[10:0], k[11]};
    endfunction

    // One full round applied to the current state and round key
    assign st_next = spn(st) ^ kr;

    // Handshake flags decode from state only, no input-to-output path
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Round FSM: accept, iterate ROUNDS times, hold result until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            st        <= 12'h000;
            kr        <= 12'h000;
            cnt       <= 4'd0;
            dout      <= 12'h000;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        st    <= din ^ key;
                        kr    <= ka(key);
                        cnt   <= 4'd1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    st <= st_next;
                    kr <= ka(kr);
                    if (cnt == LAST) begin
                        dout      <= st_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enc_round_sched.sv
// tb_enc_round_sched: directed bench for enc_round_sched with a queue
// scoreboard. Two instances run side by side: ROUNDS=2 and ROUNDS=1.
module tb_enc_round_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, in_valid1 = 1'b0;
    logic        out_ready = 1'b0, out_ready1 = 1'b0;
    logic [11:0] din = 12'h000, key = 12'h000;
    logic        in_ready, out_valid, busy;
    logic        in_ready1, out_valid1, busy1;
    logic [11:0] dout, dout1;

    int checks = 0;
    int failures = 0;
    logic [11:0] q2[$];
    logic [11:0] q1[$];
    int          acc_q[$];
    logic [11:0] out_q[$];
    int          cyc = 0;

    always #5 clk = ~clk;

    enc_round_sched #(.ROUNDS(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .din(din), .key(key),
        .out_valid(out_valid), .out_ready(out_ready),
        .dout(dout), .busy(busy)
    );

    enc_round_sched #(.ROUNDS(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .din(din), .key(key),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .dout(dout1), .busy(busy1)
    );

    // Log accept and output handshakes of the ROUNDS=2 instance
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && in_valid && in_ready) acc_q.push_back(cyc);
        if (!rst && out_valid && out_ready) out_q.push_back(dout);
    end

    // Reference model, written bit by bit from the algorithm description
    function automatic logic [11:0] ka_m(input logic [11:0] k);
        logic [11:0] r;
        for (int i = 0; i < 12; i++) r[i] = k[i] ^ ~k[(i + 11) % 12];
        return r;
    endfunction

    function automatic logic [11:0] spn_m(input logic [11:0] x);
        logic [11:0] o;
        logic a, b, c;
        o = '0;
        for (int g = 0; g < 4; g++) begin
            a = x[3*g];
            b = x[3*g+1];
            c = x[3*g+2];
            o[(3*g+2) % 12] = a;
            o[(3*g+3) % 12] = ~b;
            o[(3*g+4) % 12] = ~b ^ a ^ c;
        end
        return o;
    endfunction

    function automatic logic [11:0] enc_m(input logic [11:0] d, input logic [11:0] k, input int rounds);
        logic [11:0] s, kk;
        s  = d ^ k;
        kk = k;
        for (int r = 0; r < rounds; r++) begin
            kk = ka_m(kk);
            s  = spn_m(s) ^ kk;
        end
        return s;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic ov_of(input int sel);
        return (sel == 2) ? out_valid : out_valid1;
    endfunction

    task automatic send(input int sel, input logic [11:0] d, input logic [11:0] k);
        din = d;
        key = k;
        if (sel == 2) begin
            chk("in_ready_idle", 12'(in_ready), 12'h1);
            in_valid = 1'b1;
            step;
            in_valid = 1'b0;
            q2.push_back(enc_m(d, k, 2));
            chk("busy_after_accept", 12'(busy), 12'h1);
            chk("in_ready_after_accept", 12'(in_ready), 12'h0);
        end else begin
            chk("in_ready1_idle", 12'(in_ready1), 12'h1);
            in_valid1 = 1'b1;
            step;
            in_valid1 = 1'b0;
            q1.push_back(enc_m(d, k, 1));
            chk("busy1_after_accept", 12'(busy1), 12'h1);
        end
    endtask

    task automatic recv(input int sel, input int exp_lat, input int hold, input bit scramble);
        int n;
        logic [11:0] exp, got;
        n = 0;
        while (ov_of(sel) !== 1'b1 && n < 40) begin
            if (scramble) begin
                din = 12'($urandom);
                key = 12'($urandom);
            end
            step;
            n++;
        end
        chk("latency", 12'(n), 12'(exp_lat));
        exp = 12'hxxx;
        if (sel == 2) begin
            if (q2.size() > 0) exp = q2.pop_front();
        end else begin
            if (q1.size() > 0) exp = q1.pop_front();
        end
        got = (sel == 2) ? dout : dout1;
        chk("dout", got, exp);
        if (sel == 2) begin
            for (int h = 0; h < hold; h++) begin
                in_valid = (h == 1);
                din      = ~din;
                step;
                chk("bp_out_valid", 12'(out_valid), 12'h1);
                chk("bp_dout", dout, exp);
                chk("bp_in_ready", 12'(in_ready), 12'h0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            step;
            out_ready = 1'b0;
            chk("hs_out_valid", 12'(out_valid), 12'h0);
            chk("hs_in_ready", 12'(in_ready), 12'h1);
            chk("hs_dout_kept", dout, exp);
        end else begin
            out_ready1 = 1'b1;
            step;
            out_ready1 = 1'b0;
            chk("hs1_out_valid", 12'(out_valid1), 12'h0);
            chk("hs1_in_ready", 12'(in_ready1), 12'h1);
        end
    endtask

    initial begin
        int n;
        logic [11:0] exp;

        // Asynchronous reset asserted mid-cycle
        step;
        step;
        #3 rst = 1'b1;
        #1;
        chk("rst_in_ready", 12'(in_ready), 12'h1);
        chk("rst_out_valid", 12'(out_valid), 12'h0);
        chk("rst_busy", 12'(busy), 12'h0);
        chk("rst_dout", dout, 12'h000);
        chk("rst_cnt", 12'(dut.cnt), 12'h000);
        chk("rst_st", dut.st, 12'h000);
        chk("rst_kr", dut.kr, 12'h000);
        chk("rst_dout1", dout1, 12'h000);
        step;
        rst = 1'b0;
        step;

        // Known vector with internal round checks
        send(2, 12'hD5B, 12'hACD);
        chk("s0", dut.st, 12'hD5B ^ 12'hACD);
        chk("k1", dut.kr, ka_m(12'hACD));
        step;
        chk("s1", dut.st, spn_m(12'hD5B ^ 12'hACD) ^ ka_m(12'hACD));
        chk("k2", dut.kr, ka_m(ka_m(12'hACD)));
        chk("out_valid_early", 12'(out_valid), 12'h0);
        recv(2, 1, 0, 1'b0);

        // Zero vector on both round counts, known vector with one round
        send(2, 12'h000, 12'h000);
        recv(2, 2, 0, 1'b0);
        send(1, 12'h000, 12'h000);
        recv(1, 1, 0, 1'b0);
        send(1, 12'hD5B, 12'hACD);
        recv(1, 1, 0, 1'b0);

        // Backpressure with an ignored input pulse
        send(2, 12'h123, 12'h456);
        recv(2, 2, 5, 1'b0);

        // Inputs changing every cycle after accept
        send(2, 12'hD5B, 12'hACD);
        recv(2, 2, 0, 1'b1);

        // Back-to-back blocks with out_ready held high
        acc_q.delete();
        out_q.delete();
        din = 12'h3C5;
        key = 12'h9A7;
        for (int i = 0; i < 3; i++) q2.push_back(enc_m(12'h3C5, 12'h9A7, 2));
        out_ready = 1'b1;
        in_valid  = 1'b1;
        n = 0;
        while (acc_q.size() < 3 && n < 40) begin step; n++; end
        in_valid = 1'b0;
        n = 0;
        while (out_q.size() < 3 && n < 40) begin step; n++; end
        out_ready = 1'b0;
        chk("b2b_accepts", 12'(acc_q.size()), 12'd3);
        chk("b2b_outputs", 12'(out_q.size()), 12'd3);
        for (int i = 0; i < 3; i++) begin
            exp = (q2.size() > 0) ? q2.pop_front() : 12'hxxx;
            chk("b2b_dout", (out_q.size() > i) ? out_q[i] : 12'hxxx, exp);
        end
        for (int i = 1; i < 3; i++) begin
            chk("b2b_spacing", (acc_q.size() > i) ? 12'(acc_q[i] - acc_q[i-1]) : 12'hxxx, 12'd4);
        end

        // Reset after the first round edge aborts the block
        step;
        send(2, 12'hD5B, 12'hACD);
        step;
        #2 rst = 1'b1;
        #1;
        chk("abort_out_valid", 12'(out_valid), 12'h0);
        chk("abort_busy", 12'(busy), 12'h0);
        chk("abort_in_ready", 12'(in_ready), 12'h1);
        chk("abort_dout", dout, 12'h000);
        q2.delete();
        for (int i = 0; i < 3; i++) begin
            step;
            chk("abort_no_out", 12'(out_valid), 12'h0);
        end
        rst = 1'b0;
        step;
        send(2, 12'hD5B, 12'hACD);
        recv(2, 2, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
